if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage: the producer side of the IF/ID pipeline register.
- Keeps the PC and issues one word fetch at a time to the byte-wide memory controller.
- Assembles four little-endian bytes into a 32-bit instruction and presents pc/inst to IF/ID.
- Honours downstream halts and branch redirects from EX, including redirects that land mid-fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of PC and memory address.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- halt_i  in  1  downstream cannot accept; the held instruction stays presented.
- branch_taken_i  in  1  redirect request from EX, single-cycle pulse.
- branch_target_i  in  ADDR_W  redirect PC; valid when branch_taken_i=1.
- mem_req_o  out  1  fetch request to memory controller.
- mem_addr_o  out  ADDR_W  word address of the request; bits[1:0] are always 0.
- mem_ack_i  in  1  controller accepted the request this cycle.
- mem_rvalid_i  in  1  one data byte valid this cycle.
- mem_rdata_i  in  8  data byte.
- if_pc_o  out  ADDR_W  PC of the presented instruction; 0 when if_valid_o=0.
- if_inst_o  out  32  presented instruction; 0 (bubble) when if_valid_o=0.
- if_valid_o  out  1  if_pc_o/if_inst_o hold a valid instruction.

Behaviour:
- Reset (rst=1 at clk edge):
  - pc <= RESET_PC; state <= ISSUE; byte count <= 0; drain flag <= 0.
  - mem_req_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0.
  - The memory controller shares rst, so no in-flight bytes survive a reset; reset mid-fetch simply restarts at RESET_PC.
- States:
  - ISSUE: mem_req_o=1, mem_addr_o=pc. Go to RECV on the cycle mem_ack_i=1; otherwise keep requesting.
  - RECV: mem_req_o=0. Each mem_rvalid_i byte k (k=0..3) is written to inst[8k+7:8k]; the counter increments. When byte 3 arrives and not draining, go to HOLD.
  - HOLD: if_valid_o=1, if_pc_o=pc, if_inst_o=assembled word. If halt_i=0, then next cycle pc <= pc+4 and go to ISSUE. If halt_i=1, outputs stay stable.
- Latency: best case, ack in the ISSUE cycle and one byte per cycle, gives instruction valid 5 cycles after ISSUE is entered. Throughput is one instruction per 6 cycles without halts.
- Redirect (branch_taken_i=1):
  - In ISSUE with no ack: pc <= target and stay in ISSUE. The aborted request is never accepted.
  - In ISSUE with ack the same cycle: the request was accepted. Set drain, latch target, go to RECV.
  - In RECV: set drain and latch target into pc. Remaining bytes are consumed and discarded. After byte 3, go to ISSUE at the new pc with drain cleared.
  - In HOLD: branch wins over halt_i. Drop the held instruction, pc <= target, go to ISSUE. if_valid_o=0 the next cycle.
  - A later redirect while draining overwrites the latched target; the last redirect wins.
  - The target is used as-is except bits[1:0] are forced to 0.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W with no flag.
- mem_rvalid_i outside RECV is ignored. mem_ack_i outside ISSUE is ignored.
- Outputs are registered; no combinational path from halt_i or branch_taken_i to if_* outputs.

Test Plan:
- Reset then ack immediately, bytes 13,05,10,00 on consecutive cycles -> if_valid_o=1 with if_pc_o=0, if_inst_o=32'h00100513 after 5 cycles; next request addr=4.
- Hold halt_i=1 for 3 cycles while in HOLD -> if_pc_o/if_inst_o stable and no mem_req_o; on release, next mem_addr_o=pc+4.
- Redirect to 32'h100 after byte 1 of the fetch at 0x8 -> bytes 2,3 discarded, if_valid_o stays 0, next mem_addr_o=0x100, first valid if_pc_o=0x100.
- Redirect in the same cycle as halt_i=1 in HOLD -> held instruction dropped and the next fetch address equals the target.
- Two redirects (0x200, then 0x300) during one drain -> next mem_addr_o=0x300.
- Delayed ack (4 cycles) and gaps between rvalid bytes, plus assertion of rst mid-RECV -> correct assembly on the normal fetch; after reset, fetch restarts at RESET_PC with outputs zero.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues word fetches to a byte-wide memory controller,
// assembles little-endian bytes and presents pc/inst to the IF/ID register.
`default_nettype none

module if_fetch #(
   parameter int              ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic              mem_rvalid_i,
   input  logic [7:0]        mem_rdata_i,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [31:0]       if_inst_o,
   output logic              if_valid_o
);

   localparam logic [1:0] ISSUE = 2'd0;
   localparam logic [1:0] RECV  = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        cnt;
   logic              drain;
   logic [31:0]       inst;
   logic [ADDR_W-1:0] target;

   assign target = {branch_target_i[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ISSUE;
         pc    <= RESET_PC;
         cnt   <= 2'd0;
         drain <= 1'b0;
         inst  <= 32'd0;
      end else begin
         case (state)
            ISSUE: begin
               if (branch_taken_i)
                  pc <= target;
               // An accepted request must be drained even if a redirect arrives with the ack.
               if (mem_ack_i) begin
                  drain <= branch_taken_i;
                  cnt   <= 2'd0;
                  state <= RECV;
               end
            end
            RECV: begin
               if (branch_taken_i) begin
                  drain <= 1'b1;
                  pc    <= target;
               end
               if (mem_rvalid_i) begin
                  inst[{cnt, 3'b000} +: 8] <= mem_rdata_i;
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     if (drain || branch_taken_i) begin
                        drain <= 1'b0;
                        state <= ISSUE;
                     end else begin
                        state <= HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               if (branch_taken_i) begin
                  pc    <= target;
                  state <= ISSUE;
               end else if (!halt_i) begin
                  pc    <= pc + ADDR_W'(4);
                  state <= ISSUE;
               end
            end
            default: state <= ISSUE;
         endcase
      end
   end

   // Outputs decode registered state only; rst gates the request during reset.
   assign mem_req_o  = (state == ISSUE) && !rst;
   assign mem_addr_o = {pc[ADDR_W-1:2], 2'b00};
   assign if_valid_o = (state == HOLD);
   assign if_pc_o    = (state == HOLD) ? pc : '0;
   assign if_inst_o  = (state == HOLD) ? inst : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch.
`default_nettype none

module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        halt;
   logic        br;
   logic [31:0] br_tgt;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic        rvalid;
   logic [7:0]  rdata;
   logic [31:0] ipc;
   logic [31:0] iinst;
   logic        ivalid;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   if_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .halt_i(halt),
      .branch_taken_i(br), .branch_target_i(br_tgt),
      .mem_req_o(req), .mem_addr_o(addr), .mem_ack_i(ack),
      .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
      .if_pc_o(ipc), .if_inst_o(iinst), .if_valid_o(ivalid)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic idle();
      halt = 0; br = 0; br_tgt = 0; ack = 0; rvalid = 0; rdata = 0;
   endtask

   // Ack in current ISSUE cycle, then four back-to-back bytes; ends in HOLD.
   task automatic fetch(input logic [7:0] b0, b1, b2, b3);
      ack = 1; step(); ack = 0;
      rvalid = 1;
      rdata = b0; step();
      rdata = b1; step();
      rdata = b2; step();
      rdata = b3; step();
      rvalid = 0; rdata = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      step(); step();
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_valid", {31'd0, ivalid}, 32'd0);
      chk("rst_pc", ipc, 32'd0);
      chk("rst_inst", iinst, 32'd0);
      rst = 0; #1;
      chk("issue0_req", {31'd0, req}, 32'd1);
      chk("issue0_addr", addr, 32'h0);

      // Best-case fetch at 0
      fetch(8'h13, 8'h05, 8'h10, 8'h00);
      chk("f0_valid", {31'd0, ivalid}, 32'd1);
      chk("f0_pc", ipc, 32'h0);
      chk("f0_inst", iinst, 32'h00100513);
      chk("hold_req", {31'd0, req}, 32'd0);

      // Halt for 3 cycles
      halt = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("halt_valid", {31'd0, ivalid}, 32'd1);
         chk("halt_inst", iinst, 32'h00100513);
         chk("halt_pc", ipc, 32'h0);
         chk("halt_req", {31'd0, req}, 32'd0);
      end
      halt = 0; step();
      chk("rel_valid", {31'd0, ivalid}, 32'd0);
      chk("rel_addr", addr, 32'h4);
      chk("rel_req", {31'd0, req}, 32'd1);

      // Fetch at 4, then advance to 8
      fetch(8'h93, 8'h05, 8'h20, 8'h00);
      chk("f4_pc", ipc, 32'h4);
      chk("f4_inst", iinst, 32'h00200593);
      step();
      chk("f8_addr", addr, 32'h8);

      // Redirect to 0x100 after byte 1 of fetch at 8
      ack = 1; step(); ack = 0;
      rvalid = 1; rdata = 8'hAA; step();
      rdata = 8'hBB; step();
      rvalid = 0; br = 1; br_tgt = 32'h100; step();
      br = 0;
      rvalid = 1; rdata = 8'hCC; step();
      chk("drain_valid", {31'd0, ivalid}, 32'd0);
      rdata = 8'hDD; step();
      rvalid = 0;
      chk("drain_end_valid", {31'd0, ivalid}, 32'd0);
      chk("drain_end_addr", addr, 32'h100);
      chk("drain_end_req", {31'd0, req}, 32'd1);
      fetch(8'h13, 8'h00, 8'h00, 8'h00);
      chk("f100_valid", {31'd0, ivalid}, 32'd1);
      chk("f100_pc", ipc, 32'h100);
      chk("f100_inst", iinst, 32'h00000013);

      // Redirect together with halt in HOLD; low target bits forced to 0
      halt = 1; br = 1; br_tgt = 32'h2A3; step();
      halt = 0; br = 0;
      chk("hbr_valid", {31'd0, ivalid}, 32'd0);
      chk("hbr_inst", iinst, 32'h0);
      chk("hbr_addr", addr, 32'h2A0);
      chk("hbr_req", {31'd0, req}, 32'd1);

      // Redirect with ack, then a second redirect while draining
      ack = 1; br = 1; br_tgt = 32'h200; step();
      ack = 0; br = 0;
      rvalid = 1; rdata = 8'h11; step();
      rvalid = 0; br = 1; br_tgt = 32'h300; step();
      br = 0; rvalid = 1;
      rdata = 8'h22; step();
      rdata = 8'h33; step();
      rdata = 8'h44; step();
      rvalid = 0;
      chk("dbl_valid", {31'd0, ivalid}, 32'd0);
      chk("dbl_addr", addr, 32'h300);

      // Redirect in ISSUE without ack
      br = 1; br_tgt = 32'h400; step(); br = 0;
      chk("iss_br_addr", addr, 32'h400);
      chk("iss_br_req", {31'd0, req}, 32'd1);

      // Delayed ack with stray rvalid in ISSUE, then gapped bytes
      for (int i = 0; i < 4; i++) begin
         rvalid = 1; rdata = 8'hEE; step();
         chk("wait_req", {31'd0, req}, 32'd1);
      end
      rvalid = 0;
      chk("wait_addr", addr, 32'h400);
      ack = 1; step(); ack = 0;
      rvalid = 1; rdata = 8'h37; step();
      rvalid = 0; step();
      rvalid = 1; rdata = 8'h45; step();
      rvalid = 0; step(); step();
      rvalid = 1; rdata = 8'h23; step();
      rdata = 8'h01; step();
      rvalid = 0;
      chk("gap_valid", {31'd0, ivalid}, 32'd1);
      chk("gap_pc", ipc, 32'h400);
      chk("gap_inst", iinst, 32'h01234537);

      // pc+4 wrap-around
      br = 1; br_tgt = 32'hFFFF_FFFC; step(); br = 0;
      chk("top_addr", addr, 32'hFFFF_FFFC);
      fetch(8'h01, 8'h02, 8'h03, 8'h04);
      chk("top_pc", ipc, 32'hFFFF_FFFC);
      chk("top_inst", iinst, 32'h04030201);
      step();
      chk("wrap_addr", addr, 32'h0);

      // Reset mid-RECV
      ack = 1; step(); ack = 0;
      rvalid = 1; rdata = 8'h55; step();
      rst = 1; rdata = 8'h66; step();
      rvalid = 0;
      chk("mrst_req", {31'd0, req}, 32'd0);
      chk("mrst_valid", {31'd0, ivalid}, 32'd0);
      chk("mrst_inst", iinst, 32'h0);
      rst = 0; #1;
      chk("mrst_addr", addr, 32'h0);
      chk("mrst_req_after", {31'd0, req}, 32'd1);
      fetch(8'h13, 8'h05, 8'h10, 8'h00);
      chk("mrst_f_pc", ipc, 32'h0);
      chk("mrst_f_inst", iinst, 32'h00100513);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=%0d expected=%0d", passed, total);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
